// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the ID-stage branch resolve controller:
// branch type encodings and controller state encoding.
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/branch_resolve_ctrl_br_taken_eval.sv
// Combinational branch-taken decision from br_type and the comparator flags;
// unused encodings are flagged illegal and never taken.
module br_taken_eval
    import branch_resolve_ctrl_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       cmp_zero,
    input  logic       cmp_large,
    input  logic       cmp_little,
    input  logic       cmp_equal,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_type)
            BR_BEQ:  taken = cmp_zero;
            BR_BNE:  taken = !cmp_zero;
            BR_BLEZ: taken = cmp_little | cmp_equal;
            BR_BGTZ: taken = cmp_large;
            BR_BLTZ: taken = cmp_little;
            BR_BGEZ: taken = cmp_large | cmp_equal;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolve sequencer: stalls until operands are forwarded,
// issues a registered one-cycle PC redirect and keeps saturating perf counters.
//
//   state      | meaning
//   S_IDLE     | no branch pending; resolves immediately if operands ready
//   S_WAIT     | branch held in decode, waiting on forwarded operands
//   S_REDIRECT | redirect pulse to the PC mux; delay slot proceeds
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 8,
    parameter int PC_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [PC_W-1:0]  br_target,
    input  logic             opnd_ready,
    input  logic             cmp_zero,
    input  logic             cmp_large,
    input  logic             cmp_little,
    input  logic             cmp_equal,
    input  logic             flush,
    output logic             stall,
    output logic             br_accept,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             timeout_err,
    output logic             illegal_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_e            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              timeout_set;
    logic              resolve;
    logic              taken;
    logic              illegal;

    br_taken_eval u_taken_eval (
        .br_type    (br_type),
        .cmp_zero   (cmp_zero),
        .cmp_large  (cmp_large),
        .cmp_little (cmp_little),
        .cmp_equal  (cmp_equal),
        .taken      (taken),
        .illegal    (illegal)
    );

    assign resolve   = ((state == S_IDLE) || (state == S_WAIT)) && br_valid && opnd_ready && !flush;
    assign br_accept = resolve;
    // The delay-slot instruction must flow during the redirect cycle.
    assign stall     = br_valid && !br_accept && !flush && (state != S_REDIRECT);
    assign redirect  = (state == S_REDIRECT);

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
            wait_nxt  = '0;
        end else begin
            case (state)
                S_IDLE, S_WAIT: begin
                    if (resolve) begin
                        state_nxt = taken ? S_REDIRECT : S_IDLE;
                        wait_nxt  = '0;
                    end else if (br_valid) begin
                        state_nxt = S_WAIT;
                        if (wait_cnt != WAIT_MAX) begin
                            wait_nxt = wait_cnt + WAIT_W'(1);
                        end
                        timeout_set = (wait_nxt == WAIT_MAX);
                    end else begin
                        // decode killed the branch while it was waiting
                        state_nxt = S_IDLE;
                        wait_nxt  = '0;
                    end
                end
                S_REDIRECT: begin
                    state_nxt = S_IDLE;
                    wait_nxt  = '0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    wait_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_pc <= '0;
            timeout_err <= 1'b0;
            illegal_err <= 1'b0;
            br_cnt      <= '0;
            taken_cnt   <= '0;
        end else begin
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
            if (resolve) begin
                if (br_cnt != {CNT_W{1'b1}}) begin
                    br_cnt <= br_cnt + CNT_W'(1);
                end
                if (illegal) begin
                    illegal_err <= 1'b1;
                end
                if (taken) begin
                    redirect_pc <= br_target;
                    if (taken_cnt != {CNT_W{1'b1}}) begin
                        taken_cnt <= taken_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed cycle table,
// async reset, counter saturation and randomized cycles against a reference model.
module tb_branch_resolve_ctrl;

    localparam int CNT_W    = 10;
    localparam int MAX_WAIT = 8;
    localparam int PC_W     = 32;
    localparam int ALL1     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             br_valid = 1'b0;
    logic [2:0]       br_type = '0;
    logic [PC_W-1:0]  br_target = '0;
    logic             opnd_ready = 1'b0;
    logic             cmp_zero = 1'b0;
    logic             cmp_large = 1'b0;
    logic             cmp_little = 1'b0;
    logic             cmp_equal = 1'b0;
    logic             flush = 1'b0;
    logic             stall;
    logic             br_accept;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             timeout_err;
    logic             illegal_err;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    branch_resolve_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .PC_W(PC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .br_target   (br_target),
        .opnd_ready  (opnd_ready),
        .cmp_zero    (cmp_zero),
        .cmp_large   (cmp_large),
        .cmp_little  (cmp_little),
        .cmp_equal   (cmp_equal),
        .flush       (flush),
        .stall       (stall),
        .br_accept   (br_accept),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .timeout_err (timeout_err),
        .illegal_err (illegal_err),
        .br_cnt      (br_cnt),
        .taken_cnt   (taken_cnt)
    );

    always #5 clk = ~clk;

    // flg = {zero, large, little, equal}; exp = {stall, accept, redirect}
    typedef struct {
        bit        vld;
        bit [2:0]  typ;
        bit [31:0] tgt;
        bit        rdy;
        bit [3:0]  flg;
        bit        fl;
        bit [2:0]  exp;
        bit [31:0] e_pc;
        bit        e_terr;
        bit        e_ierr;
        int        e_brc;
        int        e_tkc;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;

    // reference model state
    bit        m_redir;
    int        m_wait;
    bit [31:0] m_pc;
    bit        m_terr, m_ierr;
    int        m_br, m_tk;

    function automatic vec_t mk(bit vld, bit [2:0] typ, bit [31:0] tgt, bit rdy, bit [3:0] flg,
                                bit fl, bit [2:0] exp, bit [31:0] pc, bit terr, bit ierr,
                                int brc, int tkc);
        vec_t t;
        t.vld = vld; t.typ = typ; t.tgt = tgt; t.rdy = rdy; t.flg = flg; t.fl = fl;
        t.exp = exp; t.e_pc = pc; t.e_terr = terr; t.e_ierr = ierr; t.e_brc = brc; t.e_tkc = tkc;
        return t;
    endfunction

    function automatic bit ref_taken(bit [2:0] typ, bit z, bit lg, bit lt, bit eq);
        case (typ)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return lt || eq;
            3'd3: return lg;
            3'd4: return lt;
            3'd5: return lg || eq;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t t);
        br_valid   = t.vld;
        br_type    = t.typ;
        br_target  = t.tgt;
        opnd_ready = t.rdy;
        {cmp_zero, cmp_large, cmp_little, cmp_equal} = t.flg;
        flush      = t.fl;
        #1;
    endtask

    task automatic model_reset();
        m_redir = 0; m_wait = 0; m_pc = '0; m_terr = 0; m_ierr = 0; m_br = 0; m_tk = 0;
    endtask

    // One rising edge; the model advances from the inputs currently driven.
    task automatic advance();
        bit acc, tk;
        acc = !m_redir && br_valid && opnd_ready && !flush;
        tk  = acc && ref_taken(br_type, cmp_zero, cmp_large, cmp_little, cmp_equal);
        @(posedge clk);
        if (acc) begin
            if (m_br < ALL1) m_br++;
            if (br_type > 3'd5) m_ierr = 1;
            if (tk) begin
                if (m_tk < ALL1) m_tk++;
                m_pc = br_target;
            end
        end
        if (flush || m_redir || acc || !br_valid) begin
            m_redir = !flush && tk;
            m_wait  = 0;
        end else begin
            m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            if (m_wait == MAX_WAIT) m_terr = 1;
        end
        @(negedge clk);
    endtask

    task automatic check_model();
        bit acc;
        acc = !m_redir && br_valid && opnd_ready && !flush;
        chk("rnd accept",   32'(br_accept),   32'(acc));
        chk("rnd stall",    32'(stall),       32'(!m_redir && br_valid && !acc && !flush));
        chk("rnd redirect", 32'(redirect),    32'(m_redir));
        chk("rnd pc",       redirect_pc,      m_pc);
        chk("rnd terr",     32'(timeout_err), 32'(m_terr));
        chk("rnd ierr",     32'(illegal_err), 32'(m_ierr));
        chk("rnd br_cnt",   32'(br_cnt),      32'(m_br));
        chk("rnd taken",    32'(taken_cnt),   32'(m_tk));
    endtask

    task automatic do_reset();
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        apply(idle);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vec_t idle, v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // BEQ taken, immediate operands
        tbl.push_back(mk(1, 0, 32'h3010, 1, 4'b1000, 0, 3'b010, 32'h0,    0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b001, 32'h3010, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h3010, 0, 0, 1, 1));
        // BGEZ with three operand-wait cycles
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 5, 32'h4000, 0, 4'b0001, 0, 3'b100, 32'h3010, 0, 0, 1, 1));
        tbl.push_back(mk(1, 5, 32'h4000, 1, 4'b0001, 0, 3'b010, 32'h3010, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b001, 32'h4000, 0, 0, 2, 2));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h4000, 0, 0, 2, 2));
        // BNE not taken, then illegal type 6
        tbl.push_back(mk(1, 1, 32'h9000, 1, 4'b1000, 0, 3'b010, 32'h4000, 0, 0, 2, 2));
        tbl.push_back(mk(1, 6, 32'h9100, 1, 4'b1111, 0, 3'b010, 32'h4000, 0, 0, 3, 2));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h4000, 0, 1, 4, 2));
        // nine wait cycles: timeout visible after the eighth edge, then flush
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(1, 0, 32'hA000, 0, 4'b0000, 0, 3'b100, 32'h4000, (i == 8), 1, 4, 2));
        tbl.push_back(mk(1, 0, 32'hA000, 0, 4'b0000, 1, 3'b000, 32'h4000, 1, 1, 4, 2));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h4000, 1, 1, 4, 2));
        // flush coincident with a taken resolve
        tbl.push_back(mk(1, 0, 32'h5000, 1, 4'b1000, 1, 3'b000, 32'h4000, 1, 1, 4, 2));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h4000, 1, 1, 4, 2));
        // branch presented in the redirect cycle is ignored
        tbl.push_back(mk(1, 0, 32'h6000, 1, 4'b1000, 0, 3'b010, 32'h4000, 1, 1, 4, 2));
        tbl.push_back(mk(1, 0, 32'h7000, 1, 4'b1000, 0, 3'b001, 32'h6000, 1, 1, 5, 3));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h6000, 1, 1, 5, 3));
        // BGTZ taken; flush during redirect does not suppress it
        tbl.push_back(mk(1, 3, 32'h8000, 1, 4'b0100, 0, 3'b010, 32'h6000, 1, 1, 5, 3));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 1, 3'b001, 32'h8000, 1, 1, 6, 4));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h8000, 1, 1, 6, 4));
        // decode kill while waiting, then BEQ not taken
        tbl.push_back(mk(1, 0, 32'hB000, 0, 4'b0000, 0, 3'b100, 32'h8000, 1, 1, 6, 4));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h8000, 1, 1, 6, 4));
        tbl.push_back(mk(1, 0, 32'hB000, 1, 4'b0000, 0, 3'b010, 32'h8000, 1, 1, 6, 4));
        tbl.push_back(mk(0, 0, 0,        0, 4'b0000, 0, 3'b000, 32'h8000, 1, 1, 7, 4));

        do_reset();
        @(negedge clk);
        apply(idle);
        chk("reset redirect", 32'(redirect),    32'h0);
        chk("reset pc",       redirect_pc,      32'h0);
        chk("reset stall",    32'(stall),       32'h0);
        chk("reset br_cnt",   32'(br_cnt),      32'h0);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk($sformatf("row%0d stall", i),    32'(stall),       32'(tbl[i].exp[2]));
            chk($sformatf("row%0d accept", i),   32'(br_accept),   32'(tbl[i].exp[1]));
            chk($sformatf("row%0d redirect", i), 32'(redirect),    32'(tbl[i].exp[0]));
            chk($sformatf("row%0d pc", i),       redirect_pc,      tbl[i].e_pc);
            chk($sformatf("row%0d terr", i),     32'(timeout_err), 32'(tbl[i].e_terr));
            chk($sformatf("row%0d ierr", i),     32'(illegal_err), 32'(tbl[i].e_ierr));
            chk($sformatf("row%0d br_cnt", i),   32'(br_cnt),      32'(tbl[i].e_brc));
            chk($sformatf("row%0d taken", i),    32'(taken_cnt),   32'(tbl[i].e_tkc));
            advance();
        end

        // async reset between edges while waiting on operands
        v = mk(1, 0, 32'hC000, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        apply(v);
        advance();
        apply(v);
        advance();
        apply(v);
        #1;
        reset = 1'b0;
        #1;
        chk("async redirect", 32'(redirect),    32'h0);
        chk("async pc",       redirect_pc,      32'h0);
        chk("async terr",     32'(timeout_err), 32'h0);
        chk("async ierr",     32'(illegal_err), 32'h0);
        chk("async br_cnt",   32'(br_cnt),      32'h0);
        chk("async taken",    32'(taken_cnt),   32'h0);
        chk("async accept",   32'(br_accept),   32'h0);
        do_reset();
        @(negedge clk);

        // counter saturation
        v = mk(1, 0, 32'hD000, 1, 4'b1000, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < ALL1 + 3; i++) begin
            apply(v);
            advance();
            apply(idle);
            advance();
        end
        chk("sat br_cnt", 32'(br_cnt),    32'(ALL1));
        chk("sat taken",  32'(taken_cnt), 32'(ALL1));
        apply(mk(1, 1, 32'hE000, 1, 4'b1000, 0, 0, 0, 0, 0, 0, 0));
        advance();
        apply(idle);
        chk("sat hold br_cnt", 32'(br_cnt),    32'(ALL1));
        chk("sat hold taken",  32'(taken_cnt), 32'(ALL1));

        // randomized cycles against the reference model
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            v = mk(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 19) == 0), 0, 0, 0, 0, 0, 0);
            apply(v);
            check_model();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
